// File: rtl/alu_cmd_sequencer_if.sv
// Signal bundle between alu_cmd_sequencer and its environment: command stream, ALU pins,
// response stream and status.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_a;
  logic [3:0]  cmd_b;
  logic [3:0]  cmd_op;
  logic        cmd_sel;

  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [15:0] alu_s;
  logic        alu_sel;
  logic [3:0]  alu_y;
  logic        alu_cout;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_y;
  logic        rsp_cout;
  logic [3:0]  rsp_op;

  logic        busy;
  logic [7:0]  done_cnt;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_sel, alu_y, alu_cout, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_s, alu_sel, rsp_valid, rsp_y, rsp_cout, rsp_op,
           busy, done_cnt
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_sel, alu_y, alu_cout, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_s, alu_sel, rsp_valid, rsp_y, rsp_cout, rsp_op,
           busy, done_cnt
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: queues commands, drives them onto a 4-bit ALU one at a time, waits
// SETTLE cycles, then returns the captured Y/Cout on a valid/ready response stream.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic                 clk,
  input logic                 rst,
  alu_cmd_sequencer_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic       sel;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StResp
  } state_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  state_t        w_state_d;
  logic [3:0]    r_settle;

  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;
  logic [3:0]    r_alu_op;
  logic          r_alu_sel;

  logic          r_rsp_valid;
  logic [3:0]    r_rsp_y;
  logic          r_rsp_cout;
  logic [3:0]    r_rsp_op;
  logic [7:0]    r_done_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_capture;
  logic          w_rsp_fire;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  cmd_t          w_head;
  cmd_t          w_cmd_in;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CW'(DEPTH));
  assign w_push       = bus.cmd_valid && !w_fifo_full;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_cmd_in     = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, sel: bus.cmd_sel};

  // ---------------------------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_cmd_in;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_pop      = 1'b0;
    w_capture  = 1'b0;
    w_rsp_fire = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_state_d = StDrive;
        end
      end
      StDrive: begin
        if (r_settle == 4'd1) begin
          w_capture = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_fire = 1'b1;
          // Back-to-back: the next command is launched on the handshake edge itself.
          if (!w_fifo_empty) begin
            w_pop     = 1'b1;
            w_state_d = StDrive;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= '0;
    end else if (w_pop) begin
      r_settle <= 4'(SETTLE);
    end else if (r_state == StDrive) begin
      r_settle <= r_settle - 4'd1;
    end
  end

  // ALU operands persist after completion; only a new pop replaces them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_alu_sel <= 1'b0;
    end else if (w_pop) begin
      r_alu_a   <= w_head.a;
      r_alu_b   <= w_head.b;
      r_alu_op  <= w_head.op;
      r_alu_sel <= w_head.sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_op    <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_y     <= bus.alu_y;
      r_rsp_cout  <= bus.alu_cout;
      r_rsp_op    <= r_alu_op;
    end else if (w_rsp_fire) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_cnt <= '0;
    end else if (w_rsp_fire) begin
      r_done_cnt <= r_done_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign bus.cmd_ready = !w_fifo_full;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_s     = {12'b0, r_alu_op};
  assign bus.alu_sel   = r_alu_sel;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_cout  = r_rsp_cout;
  assign bus.rsp_op    = r_rsp_op;
  assign bus.busy      = (r_state != StIdle) || !w_fifo_empty;
  assign bus.done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (SETTLE=1 and SETTLE=3) each driving a small ALU stub;
// results are predicted from the command list and compared in order.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if b1 ();
  alu_cmd_sequencer_if b3 ();

  alu_cmd_sequencer #(.DEPTH(4), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  alu_cmd_sequencer #(.DEPTH(4), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  int vecs = 0;
  int errs = 0;
  int exp_done1 = 0;
  int exp_done3 = 0;

  // ALU stub: op 0 add with carry, 1 and, 2 or, anything else xor.
  function automatic logic [4:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a & b};
      4'd2:    return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {b1.alu_cout, b1.alu_y} = alu_model(b1.alu_s[3:0], b1.alu_a, b1.alu_b);
  assign {b3.alu_cout, b3.alu_y} = alu_model(b3.alu_s[3:0], b3.alu_a, b3.alu_b);

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    b1.cmd_valid = 0; b1.cmd_a = 0; b1.cmd_b = 0; b1.cmd_op = 0; b1.cmd_sel = 0; b1.rsp_ready = 0;
    b3.cmd_valid = 0; b3.cmd_a = 0; b3.cmd_b = 0; b3.cmd_op = 0; b3.cmd_sel = 0; b3.rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(2);
    rst = 1'b0;
    tick(1);
    vecs++;
    if ({b1.rsp_valid, b1.cmd_ready, b1.busy} !== 3'b010) begin
      errs++; $display("FAIL reset_flags: got %b want 010", {b1.rsp_valid, b1.cmd_ready, b1.busy});
    end
    vecs++;
    if ({b1.alu_a, b1.alu_b, b1.alu_s, b1.alu_sel} !== 25'd0) begin
      errs++; $display("FAIL reset_alu: got %h want 0", {b1.alu_a, b1.alu_b, b1.alu_s, b1.alu_sel});
    end
    vecs++;
    if ({b1.rsp_y, b1.rsp_cout, b1.rsp_op, b1.done_cnt} !== 17'd0) begin
      errs++; $display("FAIL reset_rsp: got %h want 0", {b1.rsp_y, b1.rsp_cout, b1.rsp_op, b1.done_cnt});
    end
    vecs++;
    if ({b3.cmd_ready, b3.busy, b3.rsp_valid} !== 3'b100) begin
      errs++; $display("FAIL reset_dut3: got %b want 100", {b3.cmd_ready, b3.busy, b3.rsp_valid});
    end
  endtask

  task automatic test_single();
    b1.rsp_ready = 1; b1.cmd_a = 4'b1010; b1.cmd_b = 4'b1111; b1.cmd_op = 0; b1.cmd_sel = 0;
    b1.cmd_valid = 1;
    tick(1);  // after E0
    b1.cmd_valid = 0;
    vecs++;
    if ({b1.rsp_valid, b1.busy} !== 2'b01) begin
      errs++; $display("FAIL single_e0: valid,busy got %b want 01", {b1.rsp_valid, b1.busy});
    end
    tick(1);  // after E1
    vecs++;
    if ({b1.alu_a, b1.alu_b, b1.alu_sel, b1.alu_s, b1.rsp_valid} !== {4'b1010, 4'b1111, 1'b0, 16'd0, 1'b0}) begin
      errs++; $display("FAIL single_e1: a=%b b=%b s=%h valid=%b", b1.alu_a, b1.alu_b, b1.alu_s, b1.rsp_valid);
    end
    tick(1);  // after E2
    vecs++;
    if ({b1.rsp_valid, b1.rsp_y, b1.rsp_cout, b1.rsp_op} !== {1'b1, 4'b1001, 1'b1, 4'd0}) begin
      errs++; $display("FAIL single_e2: valid=%b y=%b cout=%b op=%0d want 1 1001 1 0",
                       b1.rsp_valid, b1.rsp_y, b1.rsp_cout, b1.rsp_op);
    end
    exp_done1++;
    tick(1);  // after handshake
    vecs++;
    if ({b1.done_cnt, b1.rsp_valid, b1.busy} !== {8'(exp_done1), 2'b00}) begin
      errs++; $display("FAIL single_done: cnt=%0d valid=%b busy=%b want %0d 0 0",
                       b1.done_cnt, b1.rsp_valid, b1.busy, exp_done1);
    end
    b1.rsp_ready = 0;
  endtask

  task automatic test_backpressure();
    logic [3:0] ey [3] = '{4'b1001, 4'b1010, 4'b1111};
    logic       ec [3] = '{1'b1, 1'b0, 1'b0};
    int t = 0;
    int got = 0;
    int last = 0;
    b1.rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b1.cmd_a = 4'b1010; b1.cmd_b = 4'b1111; b1.cmd_op = 4'(i); b1.cmd_sel = 0; b1.cmd_valid = 1;
      tick(1);
    end
    b1.cmd_valid = 0;
    while (!b1.rsp_valid && t < 20) begin tick(1); t++; end
    vecs++;
    if (t >= 20) begin errs++; $display("FAIL bp_first_valid: timeout got 0 want 1"); end
    for (int k = 0; k < 10; k++) begin
      vecs++;
      if ({b1.rsp_valid, b1.rsp_y, b1.rsp_cout, b1.rsp_op} !== {1'b1, 4'b1001, 1'b1, 4'd0}) begin
        errs++; $display("FAIL bp_hold[%0d]: got %b want 1_1001_1_0000", k,
                         {b1.rsp_valid, b1.rsp_y, b1.rsp_cout, b1.rsp_op});
      end
      tick(1);
    end
    b1.rsp_ready = 1;
    for (int c = 0; c < 40 && got < 3; c++) begin
      if (b1.rsp_valid) begin
        vecs++;
        if ({b1.rsp_y, b1.rsp_cout, b1.rsp_op} !== {ey[got], ec[got], 4'(got)}) begin
          errs++; $display("FAIL bp_result[%0d]: got %b want %b", got,
                           {b1.rsp_y, b1.rsp_cout, b1.rsp_op}, {ey[got], ec[got], 4'(got)});
        end
        if (got > 0) begin
          vecs++;
          if (c - last != 2) begin
            errs++; $display("FAIL bp_spacing[%0d]: got %0d want 2", got, c - last);
          end
        end
        last = c;
        got++;
        exp_done1++;
      end
      tick(1);
    end
    b1.rsp_ready = 0;
    vecs++;
    if ({got, b1.done_cnt, b1.busy} !== {32'd3, 8'(exp_done1), 1'b0}) begin
      errs++; $display("FAIL bp_end: got=%0d cnt=%0d busy=%b want 3 %0d 0", got, b1.done_cnt,
                       b1.busy, exp_done1);
    end
  endtask

  task automatic test_full();
    logic [3:0]  ca [6];
    logic [3:0]  cb [6];
    logic [3:0]  co [6];
    logic        cs [6];
    logic [17:0] q [$];
    logic [17:0] e;
    int sent = 0;
    int got = 0;
    for (int i = 0; i < 6; i++) begin
      ca[i] = 4'($urandom); cb[i] = 4'($urandom); co[i] = 4'($urandom_range(3)); cs[i] = 1'($urandom);
    end
    b1.rsp_ready = 0;
    for (int c = 0; c < 10; c++) begin
      b1.cmd_a = ca[sent]; b1.cmd_b = cb[sent]; b1.cmd_op = co[sent]; b1.cmd_sel = cs[sent];
      b1.cmd_valid = 1;
      if (b1.cmd_ready) begin
        q.push_back({ca[sent], cb[sent], co[sent], cs[sent], alu_model(co[sent], ca[sent], cb[sent])});
        sent++;
      end
      tick(1);
    end
    vecs++;
    if ({sent, b1.cmd_ready, b1.rsp_valid} !== {32'd5, 1'b0, 1'b1}) begin
      errs++; $display("FAIL full_fill: sent=%0d ready=%b valid=%b want 5 0 1", sent, b1.cmd_ready,
                       b1.rsp_valid);
    end
    b1.rsp_ready = 1;
    for (int c = 0; c < 60 && got < 6; c++) begin
      if (c == 1) begin
        vecs++;
        if (b1.cmd_ready !== 1'b1) begin
          errs++; $display("FAIL full_ready_rise: got %b want 1", b1.cmd_ready);
        end
      end
      if (b1.cmd_valid && b1.cmd_ready) begin
        q.push_back({ca[sent], cb[sent], co[sent], cs[sent], alu_model(co[sent], ca[sent], cb[sent])});
        sent++;
      end
      if (b1.rsp_valid) begin
        vecs++;
        if (q.size() == 0) begin
          errs++; $display("FAIL full_extra_rsp: got response want none");
        end else begin
          e = q.pop_front();
          if ({b1.rsp_op, b1.rsp_cout, b1.rsp_y} !== {e[9:6], e[4:0]}) begin
            errs++; $display("FAIL full_rsp[%0d]: got %h want %h", got,
                             {b1.rsp_op, b1.rsp_cout, b1.rsp_y}, {e[9:6], e[4:0]});
          end
        end
        got++;
        exp_done1++;
      end
      tick(1);
      if (sent == 6) b1.cmd_valid = 0;
    end
    b1.rsp_ready = 0;
    vecs++;
    if ({got, sent, q.size(), b1.done_cnt} !== {32'd6, 32'd6, 32'd0, 8'(exp_done1)}) begin
      errs++; $display("FAIL full_end: got=%0d sent=%0d left=%0d cnt=%0d want 6 6 0 %0d",
                       got, sent, q.size(), b1.done_cnt, exp_done1);
    end
  endtask

  task automatic test_random_stream();
    logic [17:0] q [$];
    int m = 0;
    fork
      begin
        int n = 0;
        int g = 0;
        logic acc;
        while (n < 40 && g < 2000) begin
          if (!b1.cmd_valid && $urandom_range(3) != 0) begin
            b1.cmd_a = 4'($urandom); b1.cmd_b = 4'($urandom);
            b1.cmd_op = 4'($urandom_range(3)); b1.cmd_sel = 1'($urandom);
            b1.cmd_valid = 1;
          end
          acc = b1.cmd_valid && b1.cmd_ready;
          if (acc) begin
            q.push_back({b1.cmd_a, b1.cmd_b, b1.cmd_op, b1.cmd_sel,
                         alu_model(b1.cmd_op, b1.cmd_a, b1.cmd_b)});
            n++;
          end
          tick(1);
          g++;
          if (acc) b1.cmd_valid = 0;
        end
        b1.cmd_valid = 0;
      end
      begin
        int g = 0;
        logic [17:0] e;
        while (m < 40 && g < 3000) begin
          b1.rsp_ready = ($urandom_range(2) != 0);
          if (b1.rsp_valid && b1.rsp_ready) begin
            vecs++;
            if (q.size() == 0) begin
              errs++; $display("FAIL rand_extra_rsp: got response want none");
            end else begin
              e = q.pop_front();
              if ({b1.alu_a, b1.alu_b, b1.alu_s, b1.alu_sel, b1.rsp_op, b1.rsp_cout, b1.rsp_y} !==
                  {e[17:14], e[13:10], 12'h000, e[9:6], e[5], e[9:6], e[4:0]}) begin
                errs++; $display("FAIL rand_rsp[%0d]: alu %h/%h/%h/%b rsp %h want %h", m,
                                 b1.alu_a, b1.alu_b, b1.alu_s, b1.alu_sel,
                                 {b1.rsp_op, b1.rsp_cout, b1.rsp_y}, e);
              end
            end
            m++;
            exp_done1++;
          end
          tick(1);
          g++;
        end
      end
    join
    b1.rsp_ready = 0;
    tick(1);
    vecs++;
    if ({m, b1.done_cnt, b1.busy} !== {32'd40, 8'(exp_done1), 1'b0}) begin
      errs++; $display("FAIL rand_end: rsps=%0d cnt=%0d busy=%b want 40 %0d 0", m, b1.done_cnt,
                       b1.busy, exp_done1);
    end
  endtask

  task automatic test_settle3();
    b3.rsp_ready = 1; b3.cmd_a = 4'b1010; b3.cmd_b = 4'b1111; b3.cmd_op = 1; b3.cmd_sel = 1;
    b3.cmd_valid = 1;
    tick(1);  // after E0
    b3.cmd_valid = 0;
    tick(1);  // after E1
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if ({b3.alu_a, b3.alu_b, b3.alu_s, b3.alu_sel, b3.rsp_valid} !==
          {4'b1010, 4'b1111, 16'd1, 1'b1, 1'b0}) begin
        errs++; $display("FAIL s3_drive[%0d]: a=%b b=%b s=%h sel=%b valid=%b", k, b3.alu_a,
                         b3.alu_b, b3.alu_s, b3.alu_sel, b3.rsp_valid);
      end
      tick(1);
    end
    vecs++;
    if ({b3.rsp_valid, b3.rsp_y, b3.rsp_cout, b3.rsp_op} !== {1'b1, 4'b1010, 1'b0, 4'd1}) begin
      errs++; $display("FAIL s3_rsp: got %b want 1_1010_0_0001",
                       {b3.rsp_valid, b3.rsp_y, b3.rsp_cout, b3.rsp_op});
    end
    exp_done3++;
    tick(1);
    vecs++;
    if ({b3.done_cnt, b3.busy, b3.rsp_valid} !== {8'(exp_done3), 2'b00}) begin
      errs++; $display("FAIL s3_done: cnt=%0d busy=%b valid=%b want %0d 0 0", b3.done_cnt,
                       b3.busy, b3.rsp_valid, exp_done3);
    end
    b3.rsp_ready = 0;
  endtask

  task automatic test_reset_midop();
    int t = 0;
    b3.rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b3.cmd_a = 4'hc + 4'(i); b3.cmd_b = 4'h3; b3.cmd_op = 4'd2; b3.cmd_sel = 1; b3.cmd_valid = 1;
      tick(1);
    end
    b3.cmd_valid = 0;
    vecs++;
    if ({b3.busy, b3.alu_a, b3.rsp_valid} !== {1'b1, 4'hc, 1'b0}) begin
      errs++; $display("FAIL rst_pre: busy=%b a=%h valid=%b want 1 c 0", b3.busy, b3.alu_a,
                       b3.rsp_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_done1 = 0;
    exp_done3 = 0;
    vecs++;
    if ({b3.rsp_valid, b3.rsp_y, b3.rsp_cout, b3.rsp_op, b3.alu_a, b3.alu_b, b3.alu_s,
         b3.alu_sel, b3.done_cnt, b3.busy} !== 44'd0) begin
      errs++; $display("FAIL rst_async: got %h want 0", {b3.rsp_valid, b3.rsp_y, b3.rsp_cout,
                       b3.rsp_op, b3.alu_a, b3.alu_b, b3.alu_s, b3.alu_sel, b3.done_cnt, b3.busy});
    end
    vecs++;
    if (b1.done_cnt !== 8'd0) begin
      errs++; $display("FAIL rst_async_dut1_cnt: got %0d want 0", b1.done_cnt);
    end
    tick(1);
    rst = 1'b0;
    tick(4);
    vecs++;
    if ({b3.rsp_valid, b3.busy, b3.cmd_ready} !== 3'b001) begin
      errs++; $display("FAIL rst_after: valid,busy,ready got %b want 001",
                       {b3.rsp_valid, b3.busy, b3.cmd_ready});
    end
    b3.rsp_ready = 1; b3.cmd_a = 4'b0101; b3.cmd_b = 4'b0011; b3.cmd_op = 2; b3.cmd_sel = 0;
    b3.cmd_valid = 1;
    tick(1);
    b3.cmd_valid = 0;
    while (!b3.rsp_valid && t < 12) begin tick(1); t++; end
    vecs++;
    if ({b3.rsp_valid, b3.rsp_y, b3.rsp_cout, b3.rsp_op} !== {1'b1, 4'b0111, 1'b0, 4'd2}) begin
      errs++; $display("FAIL rst_fresh_rsp: got %b want 1_0111_0_0010",
                       {b3.rsp_valid, b3.rsp_y, b3.rsp_cout, b3.rsp_op});
    end
    exp_done3++;
    tick(1);
    vecs++;
    if ({b3.done_cnt, b3.busy} !== {8'(exp_done3), 1'b0}) begin
      errs++; $display("FAIL rst_fresh_done: cnt=%0d busy=%b want 1 0", b3.done_cnt, b3.busy);
    end
    b3.rsp_ready = 0;
  endtask

  task automatic test_counter_wrap();
    logic [17:0] q [$];
    logic [17:0] e;
    int sent = 0;
    int got = 0;
    b1.rsp_ready = 1;
    for (int c = 0; c < 2000 && got < 256; c++) begin
      if (sent < 256) begin
        if (!b1.cmd_valid) begin
          b1.cmd_a = 4'($urandom); b1.cmd_b = 4'($urandom); b1.cmd_op = 4'($urandom_range(3));
          b1.cmd_sel = 1'($urandom); b1.cmd_valid = 1;
        end
      end
      if (b1.cmd_valid && b1.cmd_ready) begin
        q.push_back({b1.cmd_a, b1.cmd_b, b1.cmd_op, b1.cmd_sel,
                     alu_model(b1.cmd_op, b1.cmd_a, b1.cmd_b)});
        sent++;
        b1.cmd_valid = 0;  // new data is chosen after this edge
        b1.cmd_valid = 1;
      end
      if (b1.rsp_valid) begin
        vecs++;
        if (q.size() == 0) begin
          errs++; $display("FAIL wrap_extra_rsp: got response want none");
        end else begin
          e = q.pop_front();
          if ({b1.rsp_op, b1.rsp_cout, b1.rsp_y, b1.done_cnt} !== {e[9:6], e[4:0], 8'(got)}) begin
            errs++; $display("FAIL wrap_rsp[%0d]: got %h want %h", got,
                             {b1.rsp_op, b1.rsp_cout, b1.rsp_y, b1.done_cnt},
                             {e[9:6], e[4:0], 8'(got)});
          end
        end
        got++;
      end
      tick(1);
      if (b1.cmd_valid && sent > 0 && q.size() > 0) begin
        b1.cmd_valid = 0;
      end
    end
    b1.cmd_valid = 0;
    b1.rsp_ready = 0;
    vecs++;
    if ({got, b1.done_cnt, b1.busy} !== {32'd256, 8'd0, 1'b0}) begin
      errs++; $display("FAIL wrap_end: rsps=%0d cnt=%0d busy=%b want 256 0 0", got, b1.done_cnt,
                       b1.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full();
    test_random_stream();
    test_settle3();
    test_reset_midop();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
